// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for serial_add_sub.
// The zero port is present only when SERIAL_ADD_SUB_ZFLAG_EN is defined.
interface serial_add_sub_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef SERIAL_ADD_SUB_ZFLAG_EN
   logic             zero;

   modport master (
      output start, sub, i0, i1, cin,
      input  busy, done, sum, cout, ovf, zero
   );
   modport slave (
      input  start, sub, i0, i1, cin,
      output busy, done, sum, cout, ovf, zero
   );
`else
   modport master (
      output start, sub, i0, i1, cin,
      input  busy, done, sum, cout, ovf
   );
   modport slave (
      input  start, sub, i0, i1, cin,
      output busy, done, sum, cout, ovf
   );
`endif
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract: one BITS_PER_CYCLE-wide ripple slice reused LSB first.
// Define SERIAL_ADD_SUB_ZFLAG_EN to add the zero-result flag.
module serial_add_sub #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic             clk,
   input logic             reset,
   serial_add_sub_if.slave bus
);
   localparam int SLICES = WIDTH / BITS_PER_CYCLE;
   localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0]          a_reg, b_reg, sum_reg, sum_next;
   logic [CW-1:0]             cnt_reg;
   logic                      carry_reg, cout_reg, ovf_reg;
   logic                      busy_int, done_int;
   logic                      accept, last_slice;
   logic [BITS_PER_CYCLE:0]   rc;
   logic [BITS_PER_CYCLE-1:0] slice_sum;

   assign accept     = (state_reg == IDLE) && bus.start;
   assign last_slice = (state_reg == RUN) && (cnt_reg == LAST);

   // Operands shift right each cycle, so the slice always reads the low bits.
   assign rc[0] = carry_reg;
   genvar gi;
   generate
      for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_slice
         assign slice_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ rc[gi];
         assign rc[gi+1]      = (a_reg[gi] & b_reg[gi]) | (rc[gi] & (a_reg[gi] ^ b_reg[gi]));
      end
      for (gi = 0; gi < SLICES; gi++) begin : g_place
         assign sum_next[gi*BITS_PER_CYCLE +: BITS_PER_CYCLE] =
            (cnt_reg == CW'(gi)) ? slice_sum : sum_reg[gi*BITS_PER_CYCLE +: BITS_PER_CYCLE];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (cnt_reg == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_int = 1'b0;
      done_int = 1'b0;
      case (state_reg)
         RUN:     busy_int = 1'b1;
         DONE:    done_int = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + ~borrow_in.
         a_reg     <= bus.i0;
         b_reg     <= bus.sub ? ~bus.i1 : bus.i1;
         carry_reg <= bus.sub ^ bus.cin;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (state_reg == RUN) begin
         a_reg     <= a_reg >> BITS_PER_CYCLE;
         b_reg     <= b_reg >> BITS_PER_CYCLE;
         carry_reg <= rc[BITS_PER_CYCLE];
         sum_reg   <= sum_next;
         cnt_reg   <= last_slice ? '0 : cnt_reg + 1'b1;
         if (last_slice) begin
            cout_reg <= rc[BITS_PER_CYCLE];
            ovf_reg  <= rc[BITS_PER_CYCLE] ^ rc[BITS_PER_CYCLE-1];
         end
      end
   end

`ifdef SERIAL_ADD_SUB_ZFLAG_EN
   logic nz_reg, zero_reg;

   // Sticky OR of every written slice; the flag resolves on the last slice.
   always_ff @(posedge clk) begin
      if (reset) begin
         nz_reg   <= 1'b0;
         zero_reg <= 1'b0;
      end else if (accept) begin
         nz_reg   <= 1'b0;
         zero_reg <= 1'b0;
      end else if (state_reg == RUN) begin
         nz_reg <= nz_reg | (|slice_sum);
         if (last_slice) begin
            zero_reg <= ~(nz_reg | (|slice_sum));
         end
      end
   end

   assign bus.zero = zero_reg;
`endif

   assign bus.busy = busy_int;
   assign bus.done = done_int;
   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;
   assign bus.ovf  = ovf_reg;
endmodule
